// File: rtl/k580_sysctl_pic.sv
// k580_sysctl_pic: system controller for the k580wm80a core (status latch,
// bus strobes, CPU input mux) with an 8-input edge-triggered vectored PIC.
module k580_sysctl_pic #(
    parameter logic [7:0]  PIC_PORT   = 8'hF0,
    parameter logic [15:0] VEC_BASE   = 16'hFF00,
    parameter int unsigned VEC_STRIDE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        cpu_sync,
    input  logic        cpu_rd,
    input  logic        cpu_wr_n,
    input  logic        cpu_inta_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        cpu_intr,
    input  logic [7:0]  mem_din,
    input  logic [7:0]  io_din,
    output logic        memr,
    output logic        memw,
    output logic        ior,
    output logic        iow,
    output logic        hlta,
    input  logic [7:0]  irq
);

    localparam int unsigned NIRQ         = 8;
    localparam int unsigned SEL_W        = 3;
    localparam logic [7:0]  PIC_PORT_EOI = PIC_PORT + 8'd1;
    localparam logic [7:0]  OP_CALL      = 8'hCD;
    localparam logic [7:0]  STAT_RESET   = 8'h02;

    // Status byte bit positions
    localparam int unsigned ST_INP  = 6;
    localparam int unsigned ST_OUT  = 4;
    localparam int unsigned ST_HLTA = 3;
    localparam int unsigned ST_INTA = 0;

    typedef enum logic [1:0] {
        ACK_IDLE,
        ACK_B1,
        ACK_B2,
        ACK_B3
    } ack_state_t;

    ack_state_t         state_q;
    ack_state_t         state_d;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   sel_d;
    logic               ack_take;
    logic [7:0]         pic_byte;

    logic [7:0]         stat;
    logic [NIRQ-1:0]    imr;
    logic [NIRQ-1:0]    irr;
    logic [NIRQ-1:0]    isr;

    logic [NIRQ-1:0]    irq_s1;
    logic [NIRQ-1:0]    irq_s2;
    logic [NIRQ-1:0]    irq_s3;
    logic [NIRQ-1:0]    edge_pend;
    logic [NIRQ-1:0]    irq_rise;
    logic [NIRQ-1:0]    pend_all;

    logic               cand_vld;
    logic [SEL_W-1:0]   cand;
    logic               isr_block;
    logic [NIRQ-1:0]    eoi_mask;
    logic [NIRQ-1:0]    sel_mask;
    logic [15:0]        vec;

    logic [7:0]         io_port;
    logic               strobe_en;
    logic               imr_wr;
    logic               eoi_wr;
    logic               unused_addr_hi;

    assign io_port        = cpu_addr[7:0];
    assign unused_addr_hi = ^cpu_addr[15:8];

    // Bus strobes decoded from the latched status; suppressed in INTA and halt
    assign strobe_en = ~stat[ST_INTA] & ~stat[ST_HLTA];
    assign memr      = cpu_rd    & ~stat[ST_INP] & strobe_en;
    assign ior       = cpu_rd    &  stat[ST_INP] & strobe_en;
    assign memw      = ~cpu_wr_n & ~stat[ST_OUT] & strobe_en;
    assign iow       = ~cpu_wr_n &  stat[ST_OUT] & strobe_en;
    assign hlta      = stat[ST_HLTA];

    assign imr_wr = iow & (io_port == PIC_PORT);
    assign eoi_wr = iow & (io_port == PIC_PORT_EOI);

    assign irq_rise = irq_s2 & ~irq_s3;
    assign pend_all = edge_pend | irq_rise;
    assign sel_mask = NIRQ'(1) << sel_q;
    assign vec      = VEC_BASE + 16'(sel_q) * 16'(VEC_STRIDE);

    // Status latch, captured on the sync cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat <= STAT_RESET;
        end else if (ce && cpu_sync) begin
            stat <= cpu_dout;
        end
    end

    // Two-flop IRQ synchroniser plus delayed copy for edge detection, free-running on clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_s1 <= '0;
            irq_s2 <= '0;
            irq_s3 <= '0;
        end else begin
            irq_s1 <= irq;
            irq_s2 <= irq_s1;
            irq_s3 <= irq_s2;
        end
    end

    // Hold detected edges until the next ce cycle can post them to IRR
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_pend <= '0;
        end else if (ce) begin
            edge_pend <= '0;
        end else begin
            edge_pend <= pend_all;
        end
    end

    // Highest-priority unmasked request (lowest index wins)
    always_comb begin
        cand_vld = 1'b0;
        cand     = '0;
        for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
            if (irr[i] && !imr[i]) begin
                cand_vld = 1'b1;
                cand     = SEL_W'(i);
            end
        end
    end

    // Any in-service level at or above the candidate's priority blocks it
    always_comb begin
        isr_block = 1'b0;
        for (int i = 0; i < int'(NIRQ); i++) begin
            if (isr[i] && (SEL_W'(i) <= cand)) begin
                isr_block = 1'b1;
            end
        end
    end

    // One-hot of the lowest set ISR bit, cleared by a non-specific EOI
    always_comb begin
        eoi_mask = '0;
        for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
            if (isr[i]) begin
                eoi_mask    = '0;
                eoi_mask[i] = 1'b1;
            end
        end
    end

    // Acknowledge FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ACK_IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // Acknowledge FSM next state and the byte presented during INTA reads
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        ack_take = 1'b0;
        pic_byte = OP_CALL;
        case (state_q)
            ACK_IDLE: begin
                if (ce && cpu_sync && cpu_dout[ST_INTA]) begin
                    state_d = ACK_B1;
                    sel_d   = cand_vld ? cand : SEL_W'(NIRQ - 1);
                end
            end
            ACK_B1: begin
                pic_byte = OP_CALL;
                if (ce && !cpu_inta_n) begin
                    state_d  = ACK_B2;
                    ack_take = 1'b1;
                end
            end
            ACK_B2: begin
                pic_byte = vec[7:0];
                if (ce && !cpu_inta_n) begin
                    state_d = ACK_B3;
                end
            end
            ACK_B3: begin
                pic_byte = vec[15:8];
                if (ce && !cpu_inta_n) begin
                    state_d = ACK_IDLE;
                end
            end
            default: begin
                state_d = ACK_IDLE;
            end
        endcase
    end

    // PIC registers: IMR writes, IRR set/clear (set wins), ISR set/EOI
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imr <= '1;
            irr <= '0;
            isr <= '0;
        end else if (ce) begin
            if (imr_wr) begin
                imr <= cpu_dout;
            end
            irr <= (irr & ~(ack_take ? sel_mask : '0)) | pend_all;
            isr <= (isr & ~(eoi_wr ? eoi_mask : '0)) | (ack_take ? sel_mask : '0);
        end
    end

    // Registered interrupt request to the CPU
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_intr <= 1'b0;
        end else if (ce) begin
            cpu_intr <= cand_vld & ~isr_block & (state_q == ACK_IDLE);
        end
    end

    // CPU input bus mux: INTA byte, PIC registers, external I/O, memory
    always_comb begin
        cpu_din = mem_din;
        if (!cpu_inta_n) begin
            cpu_din = pic_byte;
        end else if (ior && (io_port == PIC_PORT)) begin
            cpu_din = imr;
        end else if (ior && (io_port == PIC_PORT_EOI)) begin
            cpu_din = irr;
        end else if (ior) begin
            cpu_din = io_din;
        end
    end

endmodule

// File: tb/tb_k580_sysctl_pic.sv
// Bench for k580_sysctl_pic: directed scenarios with literal expectations,
// then randomized bus traffic, all compared every cycle to a reference model.
module tb_k580_sysctl_pic;

    localparam logic [7:0]  PIC_PORT   = 8'hF0;
    localparam logic [15:0] VEC_BASE   = 16'hFF00;
    localparam int          VEC_STRIDE = 4;

    localparam logic [7:0] ST_FETCH  = 8'hA2;
    localparam logic [7:0] ST_MRD    = 8'h82;
    localparam logic [7:0] ST_MWR    = 8'h00;
    localparam logic [7:0] ST_IN     = 8'h42;
    localparam logic [7:0] ST_OUT    = 8'h10;
    localparam logic [7:0] ST_INTA   = 8'h23;
    localparam logic [7:0] ST_INTA2  = 8'h03;
    localparam logic [7:0] ST_STACKW = 8'h04;
    localparam logic [7:0] ST_HALT   = 8'h8A;

    localparam int K_RD   = 0;
    localparam int K_WR   = 1;
    localparam int K_INTA = 2;
    localparam int K_NONE = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic        cpu_sync = 1'b0;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr_n = 1'b1;
    logic        cpu_inta_n = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  io_din = 8'h00;
    logic [7:0]  irq = 8'h00;
    logic [7:0]  cpu_din;
    logic        cpu_intr;
    logic        memr;
    logic        memw;
    logic        ior;
    logic        iow;
    logic        hlta;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    k580_sysctl_pic dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .cpu_sync   (cpu_sync),
        .cpu_rd     (cpu_rd),
        .cpu_wr_n   (cpu_wr_n),
        .cpu_inta_n (cpu_inta_n),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_din    (cpu_din),
        .cpu_intr   (cpu_intr),
        .mem_din    (mem_din),
        .io_din     (io_din),
        .memr       (memr),
        .memw       (memw),
        .ior        (ior),
        .iow        (iow),
        .hlta       (hlta),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // h0..h2: irq as seen 1..3 clocks ago; phase: INTA bytes answered so far
    typedef struct packed {
        logic [7:0] stat;
        logic [7:0] imr;
        logic [7:0] irr;
        logic [7:0] isr;
        logic [7:0] pend;
        logic [7:0] h0;
        logic [7:0] h1;
        logic [7:0] h2;
        logic [1:0] phase;
        logic [2:0] sel;
        logic       intr;
    } mstate_t;

    mstate_t m;

    logic        e_ok;
    logic        e_memr;
    logic        e_memw;
    logic        e_ior;
    logic        e_iow;
    logic [15:0] e_vec;
    logic [7:0]  e_din;

    function automatic mstate_t model_reset();
        mstate_t r = '0;
        r.stat = 8'h02;
        r.imr  = 8'hFF;
        return r;
    endfunction

    function automatic mstate_t model_step(input mstate_t s);
        mstate_t    n = s;
        logic [7:0] rise;
        logic [7:0] pend;
        int         cand;
        int         lo;
        bit         blocked;
        rise = s.h1 & ~s.h2;
        n.h0 = irq;
        n.h1 = s.h0;
        n.h2 = s.h1;
        pend = s.pend | rise;
        if (!ce) begin
            n.pend = pend;
            return n;
        end
        n.pend = '0;
        cand = -1;
        for (int i = 7; i >= 0; i--) if (s.irr[i] && !s.imr[i]) cand = i;
        blocked = 1'b0;
        for (int i = 0; i <= cand; i++) if (s.isr[i]) blocked = 1'b1;
        n.intr = (cand >= 0) && !blocked && (s.phase == 2'd0);
        n.irr  = s.irr | pend;
        if (cpu_sync) n.stat = cpu_dout;
        if (s.phase == 2'd0) begin
            if (cpu_sync && cpu_dout[0]) begin
                n.phase = 2'd1;
                n.sel   = (cand < 0) ? 3'd7 : 3'(cand);
            end
        end else if (!cpu_inta_n) begin
            if (s.phase == 2'd1) begin
                n.irr[s.sel] = pend[s.sel];
                n.isr[s.sel] = 1'b1;
            end
            n.phase = (s.phase == 2'd3) ? 2'd0 : s.phase + 2'd1;
        end
        if (e_iow && cpu_addr[7:0] == PIC_PORT) n.imr = cpu_dout;
        if (e_iow && cpu_addr[7:0] == PIC_PORT + 8'd1) begin
            lo = -1;
            for (int i = 7; i >= 0; i--) if (s.isr[i]) lo = i;
            if (lo >= 0) n.isr[lo] = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= model_reset();
        else       m <= model_step(m);
    end

    always_comb begin
        e_ok   = !(m.stat[0] || m.stat[3]);
        e_memr = cpu_rd && !m.stat[6] && e_ok;
        e_ior  = cpu_rd &&  m.stat[6] && e_ok;
        e_memw = !cpu_wr_n && !m.stat[4] && e_ok;
        e_iow  = !cpu_wr_n &&  m.stat[4] && e_ok;
        e_vec  = VEC_BASE + 16'(int'(m.sel) * VEC_STRIDE);
        if (!cpu_inta_n) begin
            e_din = (m.phase == 2'd2) ? e_vec[7:0] : (m.phase == 2'd3) ? e_vec[15:8] : 8'hCD;
        end else if (e_ior && cpu_addr[7:0] == PIC_PORT) begin
            e_din = m.imr;
        end else if (e_ior && cpu_addr[7:0] == PIC_PORT + 8'd1) begin
            e_din = m.irr;
        end else if (e_ior) begin
            e_din = io_din;
        end else begin
            e_din = mem_din;
        end
    end

    // Every-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cpu_din",  16'(cpu_din),  16'(e_din));
            chk("memr",     16'(memr),     16'(e_memr));
            chk("memw",     16'(memw),     16'(e_memw));
            chk("ior",      16'(ior),      16'(e_ior));
            chk("iow",      16'(iow),      16'(e_iow));
            chk("hlta",     16'(hlta),     16'(m.stat[3]));
            chk("cpu_intr", 16'(cpu_intr), 16'(m.intr));
        end
    end

    // ---------------- CPU-side stimulus ----------------
    task automatic cyc(input bit c);
        ce = c;
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        int n = $urandom_range(0, 2);
        repeat (n) cyc(1'b0);
    endtask

    task automatic mcycle(input logic [7:0] st, input logic [15:0] addr, input int kind,
                          input logic [7:0] wd, output logic [7:0] rdat, output logic [3:0] strb);
        cpu_addr = addr;
        cpu_dout = st;
        cpu_sync = 1'b1;
        gap();
        cyc(1'b1);
        cpu_sync = 1'b0;
        case (kind)
            K_RD:    cpu_rd = 1'b1;
            K_WR:    begin cpu_dout = wd; cpu_wr_n = 1'b0; end
            K_INTA:  cpu_inta_n = 1'b0;
            default: ;
        endcase
        gap();
        ce = 1'b1;
        #3;
        rdat = cpu_din;
        strb = {memr, memw, ior, iow};
        @(posedge clk);
        #1;
        cpu_rd     = 1'b0;
        cpu_wr_n   = 1'b1;
        cpu_inta_n = 1'b1;
        cyc(1'b1);
    endtask

    task automatic io_in(input logic [7:0] port, output logic [7:0] d);
        logic [3:0] unused_strb;
        mcycle(ST_IN, {port, port}, K_RD, 8'h00, d, unused_strb);
    endtask

    task automatic io_out(input logic [7:0] port, input logic [7:0] d);
        logic [7:0] unused_dat;
        logic [3:0] unused_strb;
        mcycle(ST_OUT, {port, port}, K_WR, d, unused_dat, unused_strb);
    endtask

    task automatic do_ack(output logic [7:0] b0, output logic [7:0] b1, output logic [7:0] b2);
        logic [7:0] unused_dat;
        logic [3:0] unused_strb;
        mcycle(ST_INTA,   16'h1234, K_INTA, 8'h00, b0, unused_strb);
        mcycle(ST_INTA2,  16'h1234, K_INTA, 8'h00, b1, unused_strb);
        mcycle(ST_INTA2,  16'h1234, K_INTA, 8'h00, b2, unused_strb);
        mcycle(ST_STACKW, 16'h7FFF, K_WR,   8'h12, unused_dat, unused_strb);
        mcycle(ST_STACKW, 16'h7FFE, K_WR,   8'h34, unused_dat, unused_strb);
    endtask

    task automatic pulse_irq(input int n);
        irq[n] = 1'b1;
        cyc(1'b1);
        cyc(1'b1);
        irq[n] = 1'b0;
    endtask

    task automatic wait_intr(input logic exp, input string name);
        int k = 0;
        while (cpu_intr !== exp && k < 40) begin
            cyc(1'b1);
            k++;
        end
        chk(name, 16'(cpu_intr), 16'(exp));
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [3:0] s;

        reset = 1'b1;
        cyc(1'b1);
        chk_en = 1'b1;
        cyc(1'b1);
        chk("rst_intr", 16'(cpu_intr), 16'h0);
        chk("rst_hlta", 16'(hlta), 16'h0);
        chk("rst_strb", 16'({memr, memw, ior, iow}), 16'h0);
        reset = 1'b0;
        cyc(1'b1);

        // T1 memory read, then halt
        mem_din = 8'h3E;
        mcycle(ST_FETCH, 16'h0100, K_RD, 8'h00, d, s);
        chk("t1_data", 16'(d), 16'h3E);
        chk("t1_strb", 16'(s), 16'b1000);
        chk("t1_memr_off", 16'(memr), 16'h0);
        mcycle(ST_HALT, 16'h0101, K_RD, 8'h00, d, s);
        chk("t1_halt_strb", 16'(s), 16'h0);
        chk("t1_hlta", 16'(hlta), 16'h1);

        // T2 I/O
        mcycle(ST_OUT, 16'hF0F0, K_WR, 8'h55, d, s);
        chk("t2_iow", 16'(s), 16'b0001);
        io_in(8'hF0, d);
        chk("t2_imr", 16'(d), 16'h55);
        io_in(8'hF1, d);
        chk("t2_irr", 16'(d), 16'h00);
        io_din = 8'h77;
        mcycle(ST_IN, 16'h2020, K_RD, 8'h00, d, s);
        chk("t2_io", 16'(d), 16'h77);
        chk("t2_ior", 16'(s), 16'b0010);

        // T3 vectored acknowledge of IRQ3
        io_out(8'hF0, 8'h00);
        pulse_irq(3);
        wait_intr(1'b1, "t3_intr");
        do_ack(b0, b1, b2);
        chk("t3_b0", 16'(b0), 16'hCD);
        chk("t3_b1", 16'(b1), 16'h0C);
        chk("t3_b2", 16'(b2), 16'hFF);
        chk("t3_intr_low", 16'(cpu_intr), 16'h0);
        io_in(8'hF1, d);
        chk("t3_irr", 16'(d), 16'h00);
        io_out(8'hF1, 8'h00);
        cyc(1'b1);
        chk("t3_post_eoi", 16'(cpu_intr), 16'h0);

        // T4 nesting
        pulse_irq(5);
        wait_intr(1'b1, "t4_intr5");
        do_ack(b0, b1, b2);
        chk("t4_v5", 16'({b2, b1}), 16'hFF14);
        pulse_irq(2);
        wait_intr(1'b1, "t4_intr2");
        do_ack(b0, b1, b2);
        chk("t4_v2", 16'({b2, b1}), 16'hFF08);
        pulse_irq(6);
        repeat (6) cyc(1'b1);
        chk("t4_irq6_blocked", 16'(cpu_intr), 16'h0);
        io_in(8'hF1, d);
        chk("t4_irr6", 16'(d), 16'h40);
        io_out(8'hF1, 8'h00);
        repeat (4) cyc(1'b1);
        chk("t4_one_eoi", 16'(cpu_intr), 16'h0);
        io_out(8'hF1, 8'h00);
        wait_intr(1'b1, "t4_two_eoi");
        do_ack(b0, b1, b2);
        chk("t4_v6", 16'({b2, b1}), 16'hFF18);
        io_out(8'hF1, 8'h00);

        // T5 mask and single edge
        io_out(8'hF0, 8'hFB);
        irq[2] = 1'b1;
        wait_intr(1'b1, "t5_intr2");
        do_ack(b0, b1, b2);
        chk("t5_v2", 16'(b1), 16'h08);
        io_out(8'hF1, 8'h00);
        repeat (8) cyc(1'b1);
        chk("t5_level_once", 16'(cpu_intr), 16'h0);
        io_in(8'hF1, d);
        chk("t5_irr_clear", 16'(d), 16'h00);
        irq[2] = 1'b0;
        io_out(8'hF0, 8'hFF);
        pulse_irq(4);
        repeat (8) cyc(1'b1);
        chk("t5_masked", 16'(cpu_intr), 16'h0);
        io_in(8'hF1, d);
        chk("t5_irr4", 16'(d), 16'h10);
        io_out(8'hF0, 8'h00);
        chk("t5_unmask", 16'(cpu_intr), 16'h1);
        do_ack(b0, b1, b2);
        chk("t5_v4", 16'({b2, b1}), 16'hFF10);
        io_out(8'hF1, 8'h00);

        // T6 reset between INTA byte 1 and 2
        pulse_irq(1);
        wait_intr(1'b1, "t6_intr");
        mcycle(ST_INTA, 16'h2000, K_INTA, 8'h00, d, s);
        chk("t6_b0", 16'(d), 16'hCD);
        reset = 1'b1;
        cyc(1'b1);
        chk("t6_rst_strb", 16'({memr, memw, ior, iow}), 16'h0);
        chk("t6_rst_intr", 16'(cpu_intr), 16'h0);
        reset = 1'b0;
        cyc(1'b1);
        io_in(8'hF0, d);
        chk("t6_imr", 16'(d), 16'hFF);
        io_in(8'hF1, d);
        chk("t6_irr", 16'(d), 16'h00);
        mem_din = 8'hC3;
        mcycle(ST_FETCH, 16'h0000, K_RD, 8'h00, d, s);
        chk("t6_fetch", 16'(d), 16'hC3);

        // Randomized traffic
        for (int it = 0; it < 400; it++) begin
            mem_din = 8'($urandom);
            io_din  = 8'($urandom);
            if ($urandom_range(0, 2) == 0) irq = irq ^ (8'h01 << $urandom_range(0, 7));
            if (m.intr) begin
                do_ack(b0, b1, b2);
            end else begin
                case ($urandom_range(0, 9))
                    0, 1: mcycle(ST_FETCH, 16'($urandom), K_RD, 8'h00, d, s);
                    2:    mcycle(ST_MRD,   16'($urandom), K_RD, 8'h00, d, s);
                    3:    mcycle(ST_MWR,   16'($urandom), K_WR, 8'($urandom), d, s);
                    4: begin
                        d = ($urandom_range(0, 1) == 1) ? (8'hF0 + 8'($urandom_range(0, 1))) : 8'($urandom);
                        io_in(d, d);
                    end
                    5:    io_out(8'hF0, ($urandom_range(0, 2) != 0) ? 8'h00 : 8'($urandom));
                    6:    io_out(8'hF1, 8'($urandom));
                    7:    io_out(8'($urandom_range(0, 8'hEF)), 8'($urandom));
                    8:    mcycle(ST_HALT, 16'($urandom), K_RD, 8'h00, d, s);
                    default: repeat ($urandom_range(1, 4)) cyc(1'($urandom_range(0, 1)));
                endcase
            end
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
